// File: rtl/wdt_reset_gen.sv
// Two-stage watchdog on a RIB slave port: the first expiry raises an interrupt and the second raises a stretched SoC reset request.
// Define WDT_WINDOW_EN to add the WINDOW register (0x14) and the early-kick bite check.
module wdt_reset_gen #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned RST_PULSE = 16,
    parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o,
    output logic        wdt_rst_o
);

    localparam int unsigned PW = (RST_PULSE > 2) ? $clog2(RST_PULSE) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WARN = 2'd2,
        BITE = 2'd3
    } state_t;

    state_t           state;
    logic             en, int_en, rst_en, lock;
    logic [CNT_W-1:0] load, count;
    logic             int_pend, bit_cause;
    logic [PW-1:0]    bite_cnt;

    logic [7:0]       off;
    logic             wr_ok, wr_ctrl, wr_load, wr_kick, wr_status;
    logic             valid_kick, expired, early, running;
    logic             early_bite, expire_bite;
    logic             unused_addr;

`ifdef WDT_WINDOW_EN
    logic [CNT_W-1:0] window;
    logic             early_kick;
    logic             wr_window;
`endif

    // RIB access: we_i is a one-cycle write strobe qualified by addr_i/data_i on the
    // same edge; there is no back-pressure, and data_o follows addr_i combinationally.
    assign off         = addr_i[7:0];
    assign unused_addr = ^addr_i[31:8];
    assign wr_ok       = we_i && (state != BITE);
    assign wr_ctrl     = wr_ok && (off == 8'h00) && !lock;
    assign wr_load     = wr_ok && (off == 8'h04) && !lock;
    assign wr_kick     = wr_ok && (off == 8'h0C);
    assign wr_status   = wr_ok && (off == 8'h10);
    assign valid_kick  = wr_kick && (data_i == KICK_KEY);
    assign expired     = (count == '0);
    assign running     = ((state == RUN) || (state == WARN)) && en;

`ifdef WDT_WINDOW_EN
    assign wr_window = wr_ok && (off == 8'h14);
    assign early     = (count > window);
`else
    assign early     = 1'b0;
`endif

    // A kick on the expiry cycle wins, so only an unkicked WARN expiry bites.
    assign early_bite  = running && valid_kick && early && rst_en;
    assign expire_bite = running && !valid_kick && expired && (state == WARN) && rst_en;

    assign int_sig_o = int_pend & int_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en        <= 1'b0;
            int_en    <= 1'b0;
            rst_en    <= 1'b0;
            lock      <= 1'b0;
            load      <= '1;
            count     <= '0;
            int_pend  <= 1'b0;
            bit_cause <= 1'b0;
            bite_cnt  <= '0;
            wdt_rst_o <= 1'b0;
`ifdef WDT_WINDOW_EN
            window     <= '0;
            early_kick <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                en     <= data_i[0];
                int_en <= data_i[1];
                rst_en <= data_i[2];
                lock   <= data_i[3];
            end
            if (wr_load) begin
                load <= data_i[CNT_W-1:0];
            end
            if (wr_status) begin
                int_pend  <= int_pend & ~data_i[0];
                bit_cause <= bit_cause & ~data_i[1];
            end
`ifdef WDT_WINDOW_EN
            if (wr_window) begin
                window <= data_i[CNT_W-1:0];
            end
            if (wr_status && data_i[2]) begin
                early_kick <= 1'b0;
            end
            if (early_bite) begin
                early_kick <= 1'b1;
            end
`endif
            // Hardware status sets come after the W1C updates so a set wins a same-cycle clear.
            case (state)
                IDLE: begin
                    if (en) begin
                        count <= load;
                        state <= RUN;
                    end
                end
                RUN, WARN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (early_bite || expire_bite) begin
                        // The pending interrupt is retired; STATUS keeps only the bite cause.
                        state     <= BITE;
                        wdt_rst_o <= 1'b1;
                        bite_cnt  <= '0;
                        bit_cause <= 1'b1;
                        int_pend  <= 1'b0;
                    end else if (valid_kick) begin
                        count <= load;
                        state <= RUN;
                    end else if (expired) begin
                        int_pend <= 1'b1;
                        count    <= load;
                        state    <= WARN;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                BITE: begin
                    if (bite_cnt == PULSE_LAST) begin
                        wdt_rst_o <= 1'b0;
                        en        <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bite_cnt <= bite_cnt + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_o = '0;
        case (off)
            8'h00: data_o[3:0] = {lock, rst_en, int_en, en};
            8'h04: data_o[CNT_W-1:0] = load;
            8'h08: data_o[CNT_W-1:0] = count;
            8'h10: begin
                data_o[0] = int_pend;
                data_o[1] = bit_cause;
`ifdef WDT_WINDOW_EN
                data_o[2] = early_kick;
`endif
            end
`ifdef WDT_WINDOW_EN
            8'h14: data_o[CNT_W-1:0] = window;
`endif
            default: data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_wdt_reset_gen.sv
// Bench for wdt_reset_gen: randomized register scenarios with an event-timeline model of the watchdog.
// Output edges are scoreboarded by a monitor; WINDOW checks follow WDT_WINDOW_EN.
module tb_wdt_reset_gen;

    localparam int          RST_PULSE = 16;
    localparam logic [31:0] KEY       = 32'h5A5A_A5A5;
    localparam int          EW        = 34;

    localparam logic [1:0] K_INT_RISE = 2'd0;
    localparam logic [1:0] K_INT_FALL = 2'd1;
    localparam logic [1:0] K_RST_RISE = 2'd2;
    localparam logic [1:0] K_RST_FALL = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_sig_o;
    logic        wdt_rst_o;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic prev_int = 1'b0;
    logic prev_rst = 1'b0;

    wdt_reset_gen dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .int_sig_o (int_sig_o),
        .wdt_rst_o (wdt_rst_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input int c);
        exp_q.push_back({kind, 32'(c)});
    endtask

    task automatic observe(input logic [1:0] kind);
        logic [EW-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event actual kind=%0d cyc=%0d required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e !== {kind, 32'(cyc)}) begin
                n_fail++;
                $display("FAIL event actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                         kind, cyc, e[33:32], e[31:0]);
            end
        end
    endtask

    task automatic drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drained_%s actual pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: output edges seen on the falling clock, tagged with the rising-edge count.
    always @(negedge clk) begin
        if (int_sig_o !== prev_int) observe(int_sig_o ? K_INT_RISE : K_INT_FALL);
        if (wdt_rst_o !== prev_rst) observe(wdt_rst_o ? K_RST_RISE : K_RST_FALL);
        prev_int = int_sig_o;
        prev_rst = wdt_rst_o;
    end

    // ---------------- driver tasks ----------------
    // Called between a falling and the next rising edge; returns the edge number that took the write.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, output int e_n);
        we_i   = 1'b1;
        addr_i = {24'($urandom), a};
        data_i = d;
        @(negedge clk);
        we_i   = 1'b0;
        data_i = '0;
        e_n    = cyc;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        addr_i = {24'($urandom), a};
        #1;
        check(name, data_o, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Model: enable at edge w loads at w+1; RUN expiry (int) at w+L+2; WARN expiry (bite) at w+2L+3.
    task automatic run_expiry(input int l, input bit bad_kick);
        int w, x, a, b;
        logic [31:0] bad;
        wr(8'h04, 32'(l), x);
        wr(8'h00, 32'h7, w);
        a = w + l + 2;
        b = w + 2 * l + 3;
        push_ev(K_INT_RISE, a);
        push_ev(K_INT_FALL, b);
        push_ev(K_RST_RISE, b);
        push_ev(K_RST_FALL, b + RST_PULSE);
        if (bad_kick) begin
            idle(2);
            bad = $urandom;
            if (bad == KEY) bad = bad ^ 32'h1;
            wr(8'h0C, bad, x);
            rd("count_after_bad_kick", 8'h08, 32'(l - (x - w - 1)));
        end
        wait_cyc(b + RST_PULSE + 2);
        rd("ctrl_after_bite", 8'h00, 32'h6);
        rd("status_after_bite", 8'h10, 32'h2);
        wr(8'h10, 32'h7, x);
        rd("status_cleared", 8'h10, 32'h0);
        drained("expiry");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w, x, t, l, k;
        rst    = 1'b1;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        rd("rst_ctrl", 8'h00, 32'h0);
        rd("rst_load", 8'h04, 32'hFFFF_FFFF);
        rd("rst_count", 8'h08, 32'h0);
        rd("rst_kick", 8'h0C, 32'h0);
        rd("rst_status", 8'h10, 32'h0);
        rd("rst_window", 8'h14, 32'h0);
        check("rst_int", 32'(int_sig_o), 32'h0);
        check("rst_wdt", 32'(wdt_rst_o), 32'h0);
        wr(8'h20, 32'hFFFF_FFFF, x);
        rd("unmapped_read", 8'h20, 32'h0);
        wr(8'h0C, 32'h1234_5678, x);
        rd("kick_reads_zero", 8'h0C, 32'h0);

        // Plain expiry, fixed and random LOAD
        run_expiry(10, 1'b0);
        repeat (3) run_expiry($urandom_range(3, 25), 1'b0);

        // Invalid kick value has no effect
        run_expiry($urandom_range(6, 25), 1'b1);

        // Periodic valid kicks keep the watchdog quiet
        l = $urandom_range(8, 30);
        k = $urandom_range(2, l);
        wr(8'h04, 32'(l), x);
        wr(8'h00, 32'h7, w);
        while (cyc < w + 200) begin
            wr(8'h0C, KEY, x);
            idle(k - 1);
        end
        rd("status_kicked", 8'h10, 32'h0);
        wr(8'h00, 32'h0, x);
        idle(2);
        drained("kick");

        // Clearing en mid-RUN freezes COUNT
        l = $urandom_range(20, 40);
        wr(8'h04, 32'(l), x);
        wr(8'h00, 32'h7, w);
        idle($urandom_range(2, 10));
        wr(8'h00, 32'h6, x);
        rd("count_hold_0", 8'h08, 32'(l - (x - w - 1)));
        idle(4);
        rd("count_hold_1", 8'h08, 32'(l - (x - w - 1)));
        rd("status_hold", 8'h10, 32'h0);
        drained("en_clear");

        // Kick on the WARN expiry cycle wins over the bite
        l = $urandom_range(4, 20);
        wr(8'h04, 32'(l), x);
        wr(8'h00, 32'h7, w);
        push_ev(K_INT_RISE, w + l + 2);
        t = w + 2 * l + 3;
        wait_cyc(t - 1);
        wr(8'h0C, KEY, x);
        rd("count_after_warn_kick", 8'h08, 32'(l));
        rd("status_after_warn_kick", 8'h10, 32'h1);
        wr(8'h00, 32'h2, x);
        idle(l + 4);
        push_ev(K_INT_FALL, cyc + 1);
        wr(8'h10, 32'h1, x);
        rd("status_w1c", 8'h10, 32'h0);
        drained("warn_kick");

        // int_en=0 masks the interrupt, rst_en=0 keeps reloading in WARN
        l = $urandom_range(3, 10);
        wr(8'h04, 32'(l), x);
        wr(8'h00, 32'h1, w);
        wait_cyc(w + 3 * l + 8);
        rd("status_masked", 8'h10, 32'h1);
        rd("ctrl_masked", 8'h00, 32'h1);
        wr(8'h00, 32'h0, x);
        wr(8'h10, 32'h1, x);
        rd("status_masked_clr", 8'h10, 32'h0);
        drained("masked");

`ifdef WDT_WINDOW_EN
        // Early kick bites; in-window kick reloads
        wr(8'h04, 32'd100, x);
        wr(8'h14, 32'd20, x);
        rd("window_reg", 8'h14, 32'd20);
        wr(8'h00, 32'h5, w);
        t = w + 52;
        push_ev(K_RST_RISE, t);
        push_ev(K_RST_FALL, t + RST_PULSE);
        wait_cyc(t - 1);
        wr(8'h0C, KEY, x);
        wait_cyc(t + RST_PULSE + 2);
        rd("ctrl_after_early", 8'h00, 32'h4);
        rd("status_early", 8'h10, 32'h6);
        wr(8'h10, 32'h7, x);
        rd("status_early_clr", 8'h10, 32'h0);
        wr(8'h00, 32'h5, w);
        t = w + 92;
        wait_cyc(t - 1);
        wr(8'h0C, KEY, x);
        rd("count_in_window", 8'h08, 32'd100);
        rd("status_in_window", 8'h10, 32'h0);
        wr(8'h00, 32'h0, x);
        idle(2);
        drained("window");
`else
        wr(8'h14, 32'd20, x);
        rd("window_absent", 8'h14, 32'h0);
`endif

        // Lock blocks CTRL/LOAD writes; async rst mid-bite clears everything
        l = $urandom_range(5, 15);
        wr(8'h04, 32'(l), x);
        wr(8'h00, 32'hF, w);
        wr(8'h00, 32'h0, x);
        wr(8'h04, 32'd5, x);
        rd("ctrl_locked", 8'h00, 32'hF);
        rd("load_locked", 8'h04, 32'(l));
        push_ev(K_INT_RISE, w + l + 2);
        push_ev(K_INT_FALL, w + 2 * l + 3);
        push_ev(K_RST_RISE, w + 2 * l + 3);
        wait_cyc(w + 2 * l + 8);
        @(posedge clk);
        #2;
        rst = 1'b1;
        push_ev(K_RST_FALL, cyc);
        #1;
        check("rst_mid_bite_drop", 32'(wdt_rst_o), 32'h0);
        rd("rst_mid_bite_status", 8'h10, 32'h0);
        rd("rst_mid_bite_ctrl", 8'h00, 32'h0);
        rd("rst_mid_bite_load", 8'h04, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        drained("lock_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
